// File: rtl/imm_decode_stage_pkg.sv
// imm_decode_stage_pkg: format codes and RV opcode constants shared by the decode stage
package imm_decode_stage_pkg;
  localparam logic [2:0] FMT_NONE = 3'd0;
  localparam logic [2:0] FMT_I    = 3'd1;
  localparam logic [2:0] FMT_S    = 3'd2;
  localparam logic [2:0] FMT_B    = 3'd3;
  localparam logic [2:0] FMT_U    = 3'd4;
  localparam logic [2:0] FMT_J    = 3'd5;
  localparam logic [2:0] FMT_Z    = 3'd6;
  localparam logic [2:0] FMT_SH   = 3'd7;
  localparam logic [6:0] OPC_LOAD    = 7'b0000011;
  localparam logic [6:0] OPC_OPIMM   = 7'b0010011;
  localparam logic [6:0] OPC_OPIMM32 = 7'b0011011;
  localparam logic [6:0] OPC_STORE   = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH  = 7'b1100011;
  localparam logic [6:0] OPC_LUI     = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC   = 7'b0010111;
  localparam logic [6:0] OPC_JAL     = 7'b1101111;
  localparam logic [6:0] OPC_JALR    = 7'b1100111;
  localparam logic [6:0] OPC_SYSTEM  = 7'b1110011;
endpackage

// File: rtl/imm_decode_stage_extract.sv
// imm_extract: combinational opcode classification and immediate extension
module imm_extract
  import imm_decode_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  output logic [2:0]      fmt,
  output logic [XLEN-1:0] imm,
  output logic            illegal
);
  logic [6:0]  opc;
  logic [2:0]  f3;
  logic        sh;
  logic        s;
  logic [63:0] imm64;
  assign opc = instr[6:0];
  assign f3  = instr[14:12];
  assign sh  = (f3 == 3'b001) || (f3 == 3'b101);
  assign s   = instr[31];
  always_comb begin
    fmt = FMT_NONE;
    case (opc)
      OPC_LOAD, OPC_JALR:     fmt = FMT_I;
      OPC_OPIMM, OPC_OPIMM32: fmt = sh ? FMT_SH : FMT_I;
      OPC_STORE:              fmt = FMT_S;
      OPC_BRANCH:             fmt = FMT_B;
      OPC_LUI, OPC_AUIPC:     fmt = FMT_U;
      OPC_JAL:                fmt = FMT_J;
      OPC_SYSTEM:             fmt = f3[2] ? FMT_Z : FMT_NONE;
      default:                fmt = FMT_NONE;
    endcase
  end
  // built at 64 bits and truncated, so RV32 U drops the upper sign copies naturally
  always_comb begin
    imm64 = '0;
    case (fmt)
      FMT_I:   imm64 = {{52{s}}, instr[31:20]};
      FMT_S:   imm64 = {{52{s}}, instr[31:25], instr[11:7]};
      FMT_B:   imm64 = {{51{s}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
      FMT_U:   imm64 = {{32{s}}, instr[31:12], 12'b0};
      FMT_J:   imm64 = {{43{s}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
      FMT_Z:   imm64 = {59'b0, instr[19:15]};
      FMT_SH:  imm64 = (XLEN == 64 && opc == OPC_OPIMM) ? {58'b0, instr[25:20]} : {59'b0, instr[24:20]};
      default: imm64 = '0;
    endcase
  end
  assign imm = imm64[XLEN-1:0];
  assign illegal = (instr[1:0] != 2'b11) ||
                   (opc == OPC_OPIMM32 && XLEN == 32) ||
                   (fmt == FMT_SH && XLEN == 32 && instr[25]) ||
                   (opc == OPC_OPIMM32 && fmt == FMT_SH && instr[25]);
endmodule

// File: rtl/imm_decode_stage.sv
// imm_decode_stage: registered immediate decode behind a 2-entry skid buffer
module imm_decode_stage
  import imm_decode_stage_pkg::*;
#(
  parameter int XLEN          = 64,
  parameter bit RESET_PC_ZERO = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_instr,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_imm,
  output logic [2:0]      out_fmt,
  output logic [XLEN-1:0] out_target,
  output logic            out_illegal
);
  typedef struct packed {
    logic [31:0]     instr;
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] imm;
    logic [2:0]      fmt;
    logic [XLEN-1:0] target;
    logic            illegal;
  } entry_t;
  entry_t          in_e, main_d, main_q, skid_d, skid_q;
  logic            main_valid_d, main_valid_q, skid_valid_d, skid_valid_q;
  logic            acc, drain, load_main;
  logic [2:0]      fmt;
  logic [XLEN-1:0] imm, target;
  logic            illegal;
  imm_extract #(.XLEN(XLEN)) u_extract (
    .instr   (in_instr),
    .fmt     (fmt),
    .imm     (imm),
    .illegal (illegal)
  );
  assign target = (fmt == FMT_B || fmt == FMT_J || in_instr[6:0] == OPC_AUIPC) ? in_pc + imm : '0;
  assign in_e = '{instr: in_instr, pc: in_pc, imm: imm, fmt: fmt, target: target, illegal: illegal};
  assign in_ready  = !skid_valid_q;
  assign acc       = in_valid && in_ready;
  assign drain     = main_valid_q && out_ready;
  assign load_main = drain || !main_valid_q;
  // skid always refills main first so the oldest entry is presented next
  always_comb begin
    main_valid_d = flush ? 1'b0 : load_main ? (skid_valid_q || acc) : 1'b1;
    skid_valid_d = flush ? 1'b0 : skid_valid_q ? !drain : (acc && !load_main);
    main_d = !load_main ? main_q : skid_valid_q ? skid_q : acc ? in_e : main_q;
    skid_d = (acc && !load_main) ? in_e : skid_q;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
    end
  if (RESET_PC_ZERO) begin : g_rst_data
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        main_q <= '0;
        skid_q <= '0;
      end else begin
        main_q <= main_d;
        skid_q <= skid_d;
      end
  end else begin : g_nrst_data
    always_ff @(posedge clk) begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end
  assign out_valid   = main_valid_q;
  assign out_instr   = main_q.instr;
  assign out_pc      = main_q.pc;
  assign out_imm     = main_q.imm;
  assign out_fmt     = main_q.fmt;
  assign out_target  = main_q.target;
  assign out_illegal = main_q.illegal;
endmodule
